// File: rtl/decode_buffer_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for decode_buffer.
// The design takes the slave view; the fetch/ex environment takes the master view.
interface decode_buffer_if;
    logic        valid_de0;
    logic [31:0] instr_de0;
    logic        stall_de1;
    logic        stall_ex0;
    logic        valid_de1;
    logic [31:0] instr_de1;
    logic [6:0]  opcode_de1;
    logic [4:0]  rd_de1;
    logic [4:0]  rs1_de1;
    logic [4:0]  rs2_de1;
    logic [2:0]  funct3_de1;
    logic [6:0]  funct7_de1;
    logic [31:0] imm_de1;
    logic        illegal_de1;
    logic        overflow_err;

    modport slave (
        input  valid_de0, instr_de0, stall_ex0,
        output stall_de1, valid_de1, instr_de1, opcode_de1,
        output rd_de1, rs1_de1, rs2_de1, funct3_de1, funct7_de1,
        output imm_de1, illegal_de1, overflow_err
    );

    modport master (
        output valid_de0, instr_de0, stall_ex0,
        input  stall_de1, valid_de1, instr_de1, opcode_de1,
        input  rd_de1, rs1_de1, rs2_de1, funct3_de1, funct7_de1,
        input  imm_de1, illegal_de1, overflow_err
    );
endinterface

// File: rtl/decode_buffer.sv
// Decode-stage front end: in-order skid queue, RV32I field decode and
// a registered de1 output with a queue-bypass path when the queue is empty.
module decode_buffer #(
    parameter int DEPTH = 4,
    parameter int SKID  = 2
) (
    input  logic           clk,
    input  logic           reset,
    decode_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - SKID);

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] imm_q;
    logic        illegal_q;
    logic        overflow_q;

    logic        load_en;
    logic        empty;
    logic        full;
    logic        pop;
    logic        bypass;
    logic        push_req;
    logic        push;
    logic [31:0] src;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    assign load_en  = !valid_q || !bus.stall_ex0;
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop      = load_en && !empty;
    assign bypass   = load_en && empty && bus.valid_de0;
    assign push_req = bus.valid_de0 && !bypass;
    // A full queue still accepts a write when the head leaves this cycle.
    assign push     = push_req && (!full || pop);
    assign src      = pop ? mem[rd_ptr] : bus.instr_de0;

    always_comb begin
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (src[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                dec_imm = {{20{src[31]}}, src[31:20]};
            7'b0100011:
                dec_imm = {{20{src[31]}}, src[31:25], src[11:7]};
            7'b1100011:
                dec_imm = {{19{src[31]}}, src[31], src[7],
                           src[30:25], src[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                dec_imm = {src[31:12], 12'h000};
            7'b1101111:
                dec_imm = {{11{src[31]}}, src[31], src[19:12],
                           src[20], src[30:21], 1'b0};
            7'b0110011, 7'b0001111, 7'b1110011:
                dec_imm = '0;
            default:
                dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.instr_de0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else if (load_en) begin
            if (pop || bypass) begin
                valid_q   <= 1'b1;
                instr_q   <= src;
                imm_q     <= dec_imm;
                illegal_q <= dec_illegal;
            end else begin
                valid_q   <= 1'b0;
            end
        end
    end

    assign bus.stall_de1    = (count >= STALL_CNT);
    assign bus.valid_de1    = valid_q;
    assign bus.instr_de1    = instr_q;
    assign bus.opcode_de1   = instr_q[6:0];
    assign bus.rd_de1       = instr_q[11:7];
    assign bus.rs1_de1      = instr_q[19:15];
    assign bus.rs2_de1      = instr_q[24:20];
    assign bus.funct3_de1   = instr_q[14:12];
    assign bus.funct7_de1   = instr_q[31:25];
    assign bus.imm_de1      = imm_q;
    assign bus.illegal_de1  = illegal_q;
    assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_decode_buffer.sv
// Self-checking bench for decode_buffer: directed cases plus random traffic
// against a queue-based reference model of the decode stage.
module tb_decode_buffer;
    localparam int DEPTH = 4;
    localparam int SKID  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    decode_buffer_if bus ();

    decode_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mq [$];
    logic        mv;
    logic [31:0] mi;
    logic        movf;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int s;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: begin
                s = $signed(i[31:20]);
                return s;
            end
            7'h23: begin
                s = $signed({i[31:25], i[11:7]});
                return s;
            end
            7'h63: begin
                s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
                return s;
            end
            7'h37, 7'h17: return {i[31:12], 12'h000};
            7'h6f: begin
                s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
                return s;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        if (i[1:0] != 2'b11) return 1'b1;
        return !(op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6f, 7'h33, 7'h0f, 7'h73});
    endfunction

    task automatic model_reset();
        mq.delete();
        mv   = 1'b0;
        mi   = 32'h0;
        movf = 1'b0;
    endtask

    task automatic check_out(input string tag);
        logic exp_stall;
        exp_stall = (mq.size() >= DEPTH - SKID);
        chk({tag, ".valid"}, 32'(bus.valid_de1), 32'(mv));
        chk({tag, ".stall"}, 32'(bus.stall_de1), 32'(exp_stall));
        chk({tag, ".ovf"}, 32'(bus.overflow_err), 32'(movf));
        if (mv) begin
            chk({tag, ".instr"}, bus.instr_de1, mi);
            chk({tag, ".op"}, 32'(bus.opcode_de1), 32'(mi[6:0]));
            chk({tag, ".rd"}, 32'(bus.rd_de1), 32'(mi[11:7]));
            chk({tag, ".rs1"}, 32'(bus.rs1_de1), 32'(mi[19:15]));
            chk({tag, ".rs2"}, 32'(bus.rs2_de1), 32'(mi[24:20]));
            chk({tag, ".f3"}, 32'(bus.funct3_de1), 32'(mi[14:12]));
            chk({tag, ".f7"}, 32'(bus.funct7_de1), 32'(mi[31:25]));
            chk({tag, ".imm"}, bus.imm_de1, ref_imm(mi));
            chk({tag, ".ill"}, 32'(bus.illegal_de1), 32'(ref_ill(mi)));
        end
    endtask

    // Called at a falling edge: drive inputs, advance model, check next fall.
    task automatic cycle(input logic v, input logic [31:0] ins,
                         input logic s, input string tag);
        int  n;
        logic load, popm, byp, preq;
        bus.valid_de0 = v;
        bus.instr_de0 = ins;
        bus.stall_ex0 = s;
        n    = mq.size();
        load = !mv || !s;
        popm = load && n > 0;
        byp  = load && n == 0 && v;
        preq = v && !byp;
        if (popm) begin
            mi = mq.pop_front();
            mv = 1'b1;
        end else if (byp) begin
            mi = ins;
            mv = 1'b1;
        end else if (load) begin
            mv = 1'b0;
        end
        if (preq) begin
            if (n == DEPTH && !popm) movf = 1'b1;
            else mq.push_back(ins);
        end
        @(posedge clk);
        @(negedge clk);
        check_out(tag);
    endtask

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6f, 7'h33, 7'h0f, 7'h73, 7'h2b};

    initial begin
        logic [31:0] r;
        bus.valid_de0 = 1'b0;
        bus.instr_de0 = 32'h0;
        bus.stall_ex0 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(bus.valid_de1), 32'h0);
        chk("rst.stall", 32'(bus.stall_de1), 32'h0);
        chk("rst.ovf", 32'(bus.overflow_err), 32'h0);
        chk("rst.instr", bus.instr_de1, 32'h0);
        chk("rst.imm", bus.imm_de1, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        cycle(1'b1, 32'h12320193, 1'b0, "addi");
        chk("addi.valid", 32'(bus.valid_de1), 32'h1);
        chk("addi.rd", 32'(bus.rd_de1), 32'd3);
        chk("addi.rs1", 32'(bus.rs1_de1), 32'd4);
        chk("addi.f3", 32'(bus.funct3_de1), 32'd0);
        chk("addi.imm", bus.imm_de1, 32'h00000123);
        chk("addi.ill", 32'(bus.illegal_de1), 32'h0);
        cycle(1'b1, 32'h99910093, 1'b0, "addineg");
        chk("addineg.imm", bus.imm_de1, 32'hFFFFF999);
        cycle(1'b0, 32'h0, 1'b0, "idle");

        cycle(1'b1, 32'h00100093, 1'b1, "st0");
        cycle(1'b1, 32'h00200113, 1'b1, "st1");
        cycle(1'b1, 32'h00300193, 1'b1, "st2");
        chk("st.stall", 32'(bus.stall_de1), 32'h1);
        chk("st.hold", bus.instr_de1, 32'h00100093);
        cycle(1'b0, 32'h0, 1'b1, "st3");
        chk("st.hold2", bus.instr_de1, 32'h00100093);
        cycle(1'b0, 32'h0, 1'b0, "dr0");
        chk("dr0.instr", bus.instr_de1, 32'h00200113);
        chk("dr0.stall", 32'(bus.stall_de1), 32'h0);
        cycle(1'b0, 32'h0, 1'b0, "dr1");
        chk("dr1.instr", bus.instr_de1, 32'h00300193);
        cycle(1'b0, 32'h0, 1'b0, "dr2");
        chk("dr2.valid", 32'(bus.valid_de1), 32'h0);

        for (int k = 0; k < 6; k++)
            cycle(1'b1, 32'h00000013 | (32'(k + 1) << 7), 1'b1, "ovf");
        chk("ovf.flag", 32'(bus.overflow_err), 32'h1);
        chk("ovf.out", bus.instr_de1, 32'h00000093);
        for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b0, "ovdr");
        chk("ovf.sticky", 32'(bus.overflow_err), 32'h1);

        cycle(1'b1, 32'hFE000EE3, 1'b0, "beq");
        chk("beq.imm", bus.imm_de1, 32'hFFFFFFFC);
        cycle(1'b1, 32'h0000006F, 1'b0, "jal");
        chk("jal.imm", bus.imm_de1, 32'h0);
        cycle(1'b1, 32'h123450B7, 1'b0, "lui");
        chk("lui.imm", bus.imm_de1, 32'h12345000);
        cycle(1'b1, 32'hFFFFFFFF, 1'b0, "bad");
        chk("bad.ill", 32'(bus.illegal_de1), 32'h1);
        cycle(1'b0, 32'h0, 1'b0, "idle2");

        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            if ($urandom_range(7) != 0)
                r[6:0] = ops[$urandom_range(11)];
            cycle(($urandom % 4) != 0, r, ($urandom % 3) == 0, "rnd");
        end

        for (int k = 0; k < 4; k++)
            cycle(1'b1, 32'h00A00513 + 32'(k), 1'b1, "pre");
        reset = 1'b0;
        #1;
        chk("arst.valid", 32'(bus.valid_de1), 32'h0);
        chk("arst.stall", 32'(bus.stall_de1), 32'h0);
        chk("arst.ovf", 32'(bus.overflow_err), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cycle(1'b1, 32'h00500293, 1'b0, "post");
        chk("post.valid", 32'(bus.valid_de1), 32'h1);
        chk("post.instr", bus.instr_de1, 32'h00500293);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
